// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl - memory-mapped interrupt aggregator
//
// Edge-captures NUM_SRC interrupt lines into a pending register, masks them
// with an enable register and presents one interrupt request to the core.
// Sources are arbitrated by fixed priority (lowest index wins, ID = index+1)
// through a claim/complete handshake.
//
// Optional feature (macro IRQC_SYNC_EN):
//   defined   - src_i passes through a 2-flop synchronizer before edge capture
//   undefined - src_i feeds edge capture directly
//
// Ports:
//   clk_i       clock
//   reset       synchronous, active-high reset
//   src_i       interrupt source lines, bit i = source i (ID i+1)
//   address     word register index
//   writedata   bus write data
//   write       write strobe (qualified by chipselect)
//   read        read strobe (qualified by chipselect)
//   chipselect  block select
//   readdata    registered read data (updates one cycle after a read)
//   irq_o       interrupt request to core
//
// Register map:
//   0 PENDING  R, write-1-to-clear
//   1 ENABLE   R/W
//   2 CLAIM    R, side-effecting (returns winning ID, 0 if none)
//   3 COMPLETE W, writedata[4:0] = ID being completed
//   4 STATUS   {22'd0, state[1:0], 3'd0, active_id[4:0]}
//   5 RAW      live source value seen by edge capture
//   6,7        read 0, writes ignored
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [2:0]         address,
    input  logic [31:0]        writedata,
    input  logic               write,
    input  logic               read,
    input  logic               chipselect,
    output logic [31:0]        readdata,
    output logic               irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IRQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] A_PENDING  = 3'd0;
    localparam logic [2:0] A_ENABLE   = 3'd1;
    localparam logic [2:0] A_CLAIM    = 3'd2;
    localparam logic [2:0] A_COMPLETE = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;
    localparam logic [2:0] A_RAW      = 3'd5;

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_prev_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] pending_n_s;
    logic [NUM_SRC-1:0] enable_r;
    logic [NUM_SRC-1:0] masked_s;
    logic [NUM_SRC-1:0] sel_oh_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] w1c_mask_s;
    logic [NUM_SRC-1:0] claim_mask_s;
    logic [4:0]         sel_id_s;
    logic [4:0]         active_id_r;
    logic [4:0]         active_id_n_s;
    logic               any_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               claim_s;
    logic               complete_s;
    logic [31:0]        rd_mux_s;
    logic [31:0]        readdata_r;
    logic               irq_r;
    state_t             state_r;
    state_t             state_n_s;
    logic               unused_s;

`ifdef IRQC_SYNC_EN
    logic [NUM_SRC-1:0] sync1_r;
    logic [NUM_SRC-1:0] sync2_r;

    // Two-flop synchronizer for asynchronous source lines
    always_ff @(posedge clk_i) begin
        if (reset) begin
            sync1_r <= {NUM_SRC{1'b0}};
            sync2_r <= {NUM_SRC{1'b0}};
        end else begin
            sync1_r <= src_i;
            sync2_r <= sync1_r;
        end
    end

    assign src_s = sync2_r;
`else
    assign src_s = src_i;
`endif

    // Upper writedata bits carry no meaning for any register
    assign unused_s = &{1'b0, writedata};

    assign wr_en_s  = write & chipselect;
    assign rd_en_s  = read & chipselect;
    assign masked_s = pending_r & enable_r;
    assign any_s    = |masked_s;
    // Isolate the lowest set bit: that is the highest-priority request
    assign sel_oh_s = masked_s & (~masked_s + NUM_SRC'(1'b1));
    assign rise_s   = src_s & ~src_prev_r;

    // A claim only succeeds while the request is actually being presented
    assign claim_s    = rd_en_s && (address == A_CLAIM) && (state_r == ST_IRQ) && any_s;
    assign complete_s = wr_en_s && (address == A_COMPLETE) && (state_r == ST_SERVICE)
                        && (writedata[4:0] == active_id_r);

    // Convert the one-hot winner into its source ID (index + 1)
    always_comb begin
        sel_id_s = 5'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_id_s = sel_id_s | (sel_oh_s[i] ? 5'(i + 1) : 5'd0);
        end
    end

    // Pending update: clears first, new edges last so a set always wins
    always_comb begin
        w1c_mask_s   = (wr_en_s && (address == A_PENDING)) ? writedata[NUM_SRC-1:0]
                                                            : {NUM_SRC{1'b0}};
        claim_mask_s = claim_s ? sel_oh_s : {NUM_SRC{1'b0}};
        pending_n_s  = (pending_r & ~w1c_mask_s & ~claim_mask_s) | rise_s;
    end

    // Claim/complete state machine: next state and in-service ID
    always_comb begin
        state_n_s     = state_r;
        active_id_n_s = active_id_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_n_s = ST_IRQ;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_IRQ: begin
                if (claim_s) begin
                    state_n_s     = ST_SERVICE;
                    active_id_n_s = sel_id_s;
                end else if (!any_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_IRQ;
                end
            end
            ST_SERVICE: begin
                if (complete_s) begin
                    state_n_s     = ST_IDLE;
                    active_id_n_s = 5'd0;
                end else begin
                    state_n_s = ST_SERVICE;
                end
            end
            default: begin
                state_n_s     = ST_IDLE;
                active_id_n_s = 5'd0;
            end
        endcase
    end

    // Read data multiplexer, captured into readdata on a qualified read
    always_comb begin
        case (address)
            A_PENDING:  rd_mux_s = 32'(pending_r);
            A_ENABLE:   rd_mux_s = 32'(enable_r);
            A_CLAIM:    rd_mux_s = claim_s ? {27'd0, sel_id_s} : 32'd0;
            A_COMPLETE: rd_mux_s = 32'd0;
            A_STATUS:   rd_mux_s = {16'd0, 6'd0, state_r, 3'd0, active_id_r};
            A_RAW:      rd_mux_s = 32'(src_s);
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Architectural state, registered read data and registered irq
    always_ff @(posedge clk_i) begin
        if (reset) begin
            src_prev_r  <= {NUM_SRC{1'b0}};
            pending_r   <= {NUM_SRC{1'b0}};
            enable_r    <= {NUM_SRC{1'b0}};
            state_r     <= ST_IDLE;
            active_id_r <= 5'd0;
            readdata_r  <= 32'd0;
            irq_r       <= 1'b0;
        end else begin
            src_prev_r  <= src_s;
            pending_r   <= pending_n_s;
            state_r     <= state_n_s;
            active_id_r <= active_id_n_s;
            // irq mirrors the IRQ state, registered alongside it
            irq_r       <= (state_n_s == ST_IRQ);
            if (wr_en_s && (address == A_ENABLE)) begin
                enable_r <= writedata[NUM_SRC-1:0];
            end
            if (rd_en_s) begin
                readdata_r <= rd_mux_s;
            end
        end
    end

    assign readdata = readdata_r;
    assign irq_o    = irq_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl - self-checking bench for irq_ctrl
//
// Directed steps followed by randomized bus/source traffic. A behavioural
// model of the register map tracks pending/enable/state/active ID and the
// expected readdata and irq_o after every clock; directed steps also check
// fixed expected values.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam int N = 8;
`ifdef IRQC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk;
    logic          reset;
    logic [N-1:0]  src;
    logic [2:0]    address;
    logic [31:0]   writedata;
    logic          write;
    logic          read;
    logic          chipselect;
    logic [31:0]   readdata;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [N-1:0] m_pend;
    bit [N-1:0] m_en;
    bit [N-1:0] m_prev;
    bit [N-1:0] m_s1;
    bit [N-1:0] m_s2;
    int         m_state;   // 0 idle, 1 irq, 2 service
    int         m_active;
    bit [31:0]  m_rd;

    irq_ctrl #(.NUM_SRC(N)) dut (
        .clk_i      (clk),
        .reset      (reset),
        .src_i      (src),
        .address    (address),
        .writedata  (writedata),
        .write      (write),
        .read       (read),
        .chipselect (chipselect),
        .readdata   (readdata),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict the model from the current inputs, then
    // compare the DUT outputs 1 time unit after the edge.
    task automatic tick();
        bit [N-1:0] eff;
        bit [N-1:0] np;
        bit [31:0]  nrd;
        int         sel;
        int         ns;
        int         na;
        bit         any;
        bit         cs_rd;
        bit         cs_wr;
        bit         claim;
        bit [N-1:0] nen;

        eff   = (LAT > 0) ? m_s2 : src;
        cs_rd = read && chipselect;
        cs_wr = write && chipselect;
        sel   = -1;
        for (int i = 0; i < N; i++) begin
            if (sel < 0 && m_pend[i] && m_en[i]) sel = i;
        end
        any   = (sel >= 0);
        claim = cs_rd && (address == 3'd2) && (m_state == 1) && any;

        nrd = m_rd;
        if (cs_rd) begin
            case (address)
                3'd0:    nrd = 32'(m_pend);
                3'd1:    nrd = 32'(m_en);
                3'd2:    nrd = claim ? 32'(sel + 1) : 32'd0;
                3'd4:    nrd = 32'(m_state * 256 + m_active);
                3'd5:    nrd = 32'(eff);
                default: nrd = 32'd0;
            endcase
        end

        np = m_pend;
        if (cs_wr && address == 3'd0) begin
            for (int i = 0; i < N; i++) if (writedata[i]) np[i] = 1'b0;
        end
        if (claim) np[sel] = 1'b0;
        for (int i = 0; i < N; i++) if (eff[i] && !m_prev[i]) np[i] = 1'b1;

        ns = m_state;
        na = m_active;
        if (m_state == 0) begin
            ns = any ? 1 : 0;
        end else if (m_state == 1) begin
            if (claim) begin
                ns = 2;
                na = sel + 1;
            end else begin
                ns = any ? 1 : 0;
            end
        end else begin
            if (cs_wr && address == 3'd3 && int'(writedata[4:0]) == m_active) begin
                ns = 0;
                na = 0;
            end
        end

        nen = m_en;
        if (cs_wr && address == 3'd1) nen = writedata[N-1:0];

        @(posedge clk);
        #1;
        if (reset) begin
            m_pend = '0; m_en = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
            m_state = 0; m_active = 0; m_rd = 32'd0;
        end else begin
            m_pend = np; m_en = nen; m_prev = eff;
            m_s2 = m_s1; m_s1 = src;
            m_state = ns; m_active = na; m_rd = nrd;
        end
        chk("irq_o", 32'(irq_o), 32'(m_state == 1));
        chk("readdata", readdata, m_rd);
    endtask

    task automatic bus_idle();
        write = 1'b0; read = 1'b0; chipselect = 1'b0;
        address = 3'd0; writedata = 32'd0;
    endtask

    task automatic do_read(input logic [2:0] a);
        address = a; read = 1'b1; chipselect = 1'b1; write = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1; chipselect = 1'b1; read = 1'b0;
        tick();
        bus_idle();
    endtask

    initial begin
        int op;
        reset = 1'b1;
        src   = '0;
        bus_idle();
        m_pend = '0; m_en = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_state = 0; m_active = 0; m_rd = 32'd0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // Reset: every register reads 0
        chk("reset_irq", 32'(irq_o), 32'd0);
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a));
            chk("reset_reg", readdata, 32'd0);
        end

        // Single source, full claim/complete handshake
        do_write(3'd1, 32'h01);
        src = 8'h01;
        tick();
        src = 8'h00;
        repeat (LAT) tick();
        chk("pulse_irq_still_low", 32'(irq_o), 32'd0);
        do_read(3'd0);
        chk("pending_after_pulse", readdata, 32'h01);
        chk("irq_high_k1", 32'(irq_o), 32'd1);
        do_read(3'd2);
        chk("claim_id1", readdata, 32'd1);
        chk("irq_low_after_claim", 32'(irq_o), 32'd0);
        do_read(3'd4);
        chk("status_service1", readdata, 32'h201);
        do_write(3'd3, 32'd1);
        do_read(3'd4);
        chk("status_idle", readdata, 32'h0);

        // Two simultaneous sources: priority order
        do_write(3'd1, 32'hFF);
        src = 8'h24;
        tick();
        repeat (LAT) tick();
        tick();
        chk("irq_two_src", 32'(irq_o), 32'd1);
        do_read(3'd5);
        chk("raw_value", readdata, 32'h24);
        do_read(3'd2);
        chk("claim_id3", readdata, 32'd3);
        do_write(3'd3, 32'd3);
        tick();
        chk("irq_reassert", 32'(irq_o), 32'd1);
        do_read(3'd2);
        chk("claim_id6", readdata, 32'd6);
        src = 8'h00;
        do_write(3'd3, 32'd6);

        // Masked source, enable later, then clear before claim
        do_write(3'd1, 32'h00);
        src = 8'h02;
        tick();
        src = 8'h00;
        repeat (LAT) tick();
        tick();
        chk("masked_irq_low", 32'(irq_o), 32'd0);
        do_read(3'd0);
        chk("masked_pending", readdata, 32'h02);
        do_write(3'd1, 32'h02);
        tick();
        chk("unmask_irq_high", 32'(irq_o), 32'd1);
        do_write(3'd0, 32'h02);
        tick();
        chk("w1c_irq_low", 32'(irq_o), 32'd0);
        do_read(3'd4);
        chk("w1c_status_idle", readdata, 32'h0);

        // Wrong complete ID and claim during service are ignored
        do_write(3'd1, 32'h01);
        src = 8'h01;
        tick();
        src = 8'h00;
        repeat (LAT) tick();
        tick();
        do_read(3'd2);
        chk("claim_svc", readdata, 32'd1);
        do_write(3'd3, 32'd4);
        do_read(3'd4);
        chk("bad_complete_ignored", readdata, 32'h201);
        do_read(3'd2);
        chk("claim_in_service_zero", readdata, 32'd0);
        do_write(3'd3, 32'd1);
        do_read(3'd4);
        chk("complete_ok", readdata, 32'h0);

        // Edge set beats W1C; a held level sets pending only once
        src = 8'h01;
        address = 3'd0; writedata = 32'h01; write = 1'b1; chipselect = 1'b1;
        tick();
        bus_idle();
        repeat (LAT) tick();
        do_read(3'd0);
        chk("set_wins_w1c", 32'(readdata[0]), 32'd1);
        do_read(3'd2);
        chk("claim_held", readdata, 32'd1);
        repeat (8) tick();
        do_read(3'd0);
        chk("held_no_reset", readdata, 32'h0);
        do_write(3'd3, 32'd1);
        src = 8'h00;
        tick();

        // Reset in the middle of service drops everything
        do_write(3'd1, 32'h08);
        src = 8'h08;
        tick();
        src = 8'h00;
        repeat (LAT) tick();
        tick();
        do_read(3'd2);
        chk("claim_id4", readdata, 32'd4);
        src = 8'h08;
        tick();
        src = 8'h00;
        repeat (LAT) tick();
        chk("svc_accum_irq_low", 32'(irq_o), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_irq", 32'(irq_o), 32'd0);
        chk("midreset_readdata", readdata, 32'd0);
        do_read(3'd0);
        chk("midreset_pending", readdata, 32'd0);
        do_read(3'd4);
        chk("midreset_status", readdata, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) src[$urandom_range(0, N - 1)] ^= 1'b1;
            bus_idle();
            chipselect = ($urandom_range(0, 7) != 0);
            op = $urandom_range(0, 5);
            case (op)
                1: begin read = 1'b1; address = 3'($urandom_range(0, 7)); end
                2, 3: begin read = 1'b1; address = 3'd2; end
                4: begin
                    write = 1'b1;
                    address = 3'($urandom_range(0, 7));
                    writedata = $urandom;
                    if (address == 3'd3 && $urandom_range(0, 1) == 1)
                        writedata = 32'(m_active);
                end
                5: begin write = 1'b1; address = 3'd3; writedata = 32'(m_active); end
                default: begin end
            endcase
            tick();
        end
        reset = 1'b0;
        bus_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt aggregator placed directly downstream of the timer and other uncore peripherals.
- Edge-captures per-source interrupt lines (e.g. the timer's one-cycle intr_o pulse) into a pending register and masks them with an enable register.
- Drives a single irq_o to the core and arbitrates sources by fixed priority through a claim/complete handshake.
- Uses the same slave bus protocol as the other uncore peripherals: address, write, read, chipselect, registered readdata.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..31; source i has ID i+1.

Ports:
- clk_i  input  1  clock
- reset  input  1  synchronous, active-high reset
- src_i  input  NUM_SRC  interrupt source lines, bit i = source i
- address  input  3  word register index
- writedata  input  32  bus write data
- write  input  1  write strobe (qualified by chipselect)
- read  input  1  read strobe (qualified by chipselect)
- chipselect  input  1  block select
- readdata  output  32  registered read data
- irq_o  output  1  interrupt request to core

Behaviour:
- Clock/reset: one clock clk_i; reset is synchronous and active-high, sampled on posedge clk_i.
- Reset values: pending, enable, src_prev, in-service ID, readdata all 0; state IDLE; irq_o 0.
- Register map (address):
  - 0 PENDING: R; write-1-to-clear.
  - 1 ENABLE: R/W, bits [NUM_SRC-1:0].
  - 2 CLAIM: read-only, side-effecting.
  - 3 COMPLETE: write-only, writedata[4:0] = ID.
  - 4 STATUS: {16'd0, 6'd0, state[1:0], 3'd0, active_id[4:0]}.
  - 5 RAW: live src_i (after sync if enabled).
  - 6, 7: read 0, writes ignored.
- Bus:
  - Unused upper bits read 0.
  - readdata updates one cycle after a read & chipselect cycle; otherwise holds its value.
  - Write-only registers read 0.
- Edge capture:
  - src_prev <= src each cycle.
  - pending[i] sets when src[i] & ~src_prev[i].
  - Set has priority over a W1C clear of the same bit in the same cycle.
  - Level-held sources do not re-set pending until they deassert and re-rise.
- Selection:
  - sel = lowest index i with pending[i] & enable[i].
  - any = |(pending & enable).
- State machine:
  - IDLE -> IRQ when any.
  - IRQ -> IDLE when any = 0 (masked or cleared before claim).
  - IRQ -> SERVICE on a CLAIM read: readdata = sel+1, pending[sel] cleared, active_id <= sel+1.
  - SERVICE -> IDLE on a COMPLETE write with writedata[4:0] == active_id; active_id <= 0.
  - A COMPLETE write with a mismatched ID, or in IDLE/IRQ, is ignored.
  - A CLAIM read in IDLE or SERVICE returns 0 and changes no state.
- irq_o = (state == IRQ).
- Latency: rising edge sampled at posedge k -> pending set after k -> irq_o high after posedge k+1.
- Simultaneous events:
  - A new edge on the source being claimed in the claim cycle re-sets pending (set wins).
  - A disable of the selected source in the claim cycle: the claim still uses the pre-write ENABLE.
- Sources firing during SERVICE accumulate in pending; irq_o stays low until complete.
- Reset mid-SERVICE: returns to IDLE and drops all pending bits.

Optional Feature:
- Macro: IRQC_SYNC_EN.
- Defined: src_i passes through a 2-flop synchronizer before edge capture; latency to irq_o becomes k+3; RAW shows the synchronized value; synchronizer flops reset to 0.
- Undefined: src_i is used directly; latency k+1.

Test Plan:
- Reset, then read all registers -> every register reads 0; irq_o = 0.
- ENABLE = 0x01; pulse src_i[0] one cycle at posedge k -> PENDING = 0x01; irq_o high after k+1; CLAIM read returns 1; irq_o falls; STATUS active_id = 1; COMPLETE write 1 -> state IDLE.
- ENABLE = 0xFF; raise src_i[5] and src_i[2] in the same cycle -> first CLAIM returns 3; COMPLETE 3 -> irq_o reasserts; second CLAIM returns 6.
- ENABLE = 0x00; pulse src_i[1] -> PENDING = 0x02, irq_o stays 0. Then ENABLE = 0x02 -> irq_o high. Then write PENDING 0x02 -> irq_o low, state IDLE.
- In SERVICE with active_id 1: COMPLETE 4 -> ignored, state stays SERVICE; CLAIM read -> returns 0.
- Pulse src_i[0] in the same cycle as a W1C of bit 0 -> PENDING bit 0 = 1. Hold src_i[0] high 10 cycles -> only one pending set.
